// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: sequencer states, default parameters and the divide-ratio helper.
package clk_rst_pkg;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_DIV_W    = 8;
    localparam int DEF_RST_HOLD = 4;
    localparam int DEF_STAGGER  = 2;
    localparam int DEF_CYC_W    = 32;

    typedef enum logic [1:0] {HOLD, RELEASE, RUN, DONE} seq_state_e;

    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d == '0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/clk_rst_seq_ch.sv
// clk_div_ch: one divider channel producing a clock-enable pulse and a divided clock level.
module clk_div_ch
    import clk_rst_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             ce_o,
    output logic             div_clk_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_new;
    logic             ce_q, ce_d, dclk_q, dclk_d, wrap;

    always_comb begin
        div_new = DIV_W'(eff_div(32'(div_i)));
        wrap    = run_i && (cnt_q == div_q - 1'b1);
        cnt_d   = !run_i ? cnt_q : (wrap ? '0 : cnt_q + 1'b1);
        div_d   = wrap ? div_new : div_q;
        ce_d    = wrap;
        dclk_d  = dclk_q ^ wrap;
    end

    // the ratio keeps reloading while held, so release picks up the latest value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            div_q  <= div_new;
            ce_q   <= 1'b0;
            dclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            ce_q   <= ce_d;
            dclk_q <= dclk_d;
        end
    end

    assign ce_o      = ce_q;
    assign div_clk_o = dclk_q;

endmodule

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: staggered reset release, per-channel clock dividers and a bounded cycle budget.
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int RST_HOLD = DEF_RST_HOLD,
    parameter int STAGGER  = DEF_STAGGER,
    parameter int CYC_W    = DEF_CYC_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [CYC_W-1:0]        max_cycles_i,
    output logic [NUM_CH-1:0]       rst_n_o,
    output logic [NUM_CH-1:0]       ce_o,
    output logic [NUM_CH-1:0]       div_clk_o,
    output logic [CYC_W-1:0]        cycle_cnt_o,
    output logic                    done_o
);

    localparam int REL_MAX = RST_HOLD + (NUM_CH - 1) * STAGGER;
    localparam int HOLD_W  = $clog2(REL_MAX + 1);

    seq_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [NUM_CH-1:0] rst_n_q, rst_n_d, ch_rst, ch_run;
    logic [CYC_W-1:0]  cyc_q, cyc_d, cyc_inc;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rst_n_d = rst_n_q;
        cyc_d   = cyc_q;
        cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
        case (state_q)
            HOLD, RELEASE: begin
                hold_d = (hold_q < HOLD_W'(REL_MAX)) ? hold_q + 1'b1 : hold_q;
                for (int k = 0; k < NUM_CH; k++)
                    if (int'(hold_d) >= RST_HOLD + k * STAGGER) rst_n_d[k] = 1'b1;
                state_d = (&rst_n_d) ? RUN : ((|rst_n_d) ? RELEASE : HOLD);
            end
            RUN: begin
                if (en_i) begin
                    cyc_d = cyc_inc;
                    if (max_cycles_i != '0 && cyc_inc >= max_cycles_i) state_d = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HOLD;
            hold_q  <= '0;
            rst_n_q <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rst_n_q <= rst_n_d;
            cyc_q   <= cyc_d;
        end
    end

    // an unreleased channel is simply held in its own reset
    assign ch_rst = {NUM_CH{rst_i}} | ~rst_n_q;
    assign ch_run = rst_n_q & {NUM_CH{en_i && state_q != DONE}};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_ch #(.DIV_W(DIV_W)) u_ch (
            .clk_i     (clk_i),
            .rst_i     (ch_rst[c]),
            .run_i     (ch_run[c]),
            .div_i     (div_i[c*DIV_W +: DIV_W]),
            .ce_o      (ce_o[c]),
            .div_clk_o (div_clk_o[c])
        );
    end

    assign rst_n_o     = rst_n_q;
    assign cycle_cnt_o = cyc_q;
    assign done_o      = state_q == DONE;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: event-level model of two sequencers (stagger 2 and 0) checked every cycle,
// plus literal release edges, half-periods, ratio-change spacing and budget endpoints.
module tb_clk_rst_seq;

    logic        clk, rst, en;
    logic [31:0] max_c;
    logic [31:0] div_v   [2];
    logic [3:0]  rstn_w  [2];
    logic [3:0]  ce_w    [2];
    logic [3:0]  dclk_w  [2];
    logic [31:0] cnt_w   [2];
    logic        done_w  [2];

    int checks = 0;
    int errors = 0;

    clk_rst_seq #(.NUM_CH(4), .DIV_W(8), .RST_HOLD(4), .STAGGER(2), .CYC_W(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .div_i(div_v[0]), .max_cycles_i(max_c),
        .rst_n_o(rstn_w[0]), .ce_o(ce_w[0]), .div_clk_o(dclk_w[0]),
        .cycle_cnt_o(cnt_w[0]), .done_o(done_w[0])
    );

    clk_rst_seq #(.NUM_CH(4), .DIV_W(8), .RST_HOLD(4), .STAGGER(0), .CYC_W(32)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .div_i(div_v[1]), .max_cycles_i(max_c),
        .rst_n_o(rstn_w[1]), .ce_o(ce_w[1]), .div_clk_o(dclk_w[1]),
        .cycle_cnt_o(cnt_w[1]), .done_o(done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state: edges since reset, and per channel the edges left until its next pulse
    int          ecnt = 0;
    bit          mrel [2][4];
    int          left [2][4];
    bit          mce  [2][4];
    bit          mclk [2][4];
    logic [31:0] mcnt [2];
    bit          mdone[2];

    int          rise [2][4];
    logic [3:0]  prev_rn[2];
    logic [3:0]  prev_dc;
    int          last_tog[4];
    bit          per_on = 1'b0;

    function automatic int stag(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int effd(input int i, input int k);
        int d;
        d = int'(div_v[i][k*8 +: 8]);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    task automatic model_edge();
        bit all_rel;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) begin
                    mrel[i][k] = 0; mce[i][k] = 0; mclk[i][k] = 1; left[i][k] = 0;
                end
                mcnt[i]  = 0;
                mdone[i] = 0;
            end else begin
                all_rel = 1;
                for (int k = 0; k < 4; k++) all_rel &= mrel[i][k];
                for (int k = 0; k < 4; k++) begin
                    mce[i][k] = 0;
                    if (mrel[i][k]) begin
                        if (en && !mdone[i]) begin
                            left[i][k]--;
                            if (left[i][k] == 0) begin
                                mce[i][k]  = 1;
                                mclk[i][k] = !mclk[i][k];
                                left[i][k] = effd(i, k);
                            end
                        end
                    end else if (ecnt == 4 + k * stag(i)) begin
                        mrel[i][k] = 1;
                        left[i][k] = effd(i, k);
                    end
                end
                if (all_rel && !mdone[i] && en) begin
                    if (mcnt[i] != 32'hFFFF_FFFF) mcnt[i]++;
                    if (max_c != 0 && mcnt[i] >= max_c) mdone[i] = 1;
                end
            end
        end
    endtask

    task automatic compare();
        logic [3:0] er, ec, ed;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) begin
                er[k] = mrel[i][k]; ec[k] = mce[i][k]; ed[k] = mclk[i][k];
            end
            chk($sformatf("rst_n_o[%0d]", i), rstn_w[i], er);
            chk($sformatf("ce_o[%0d]", i), ce_w[i], ec);
            chk($sformatf("div_clk_o[%0d]", i), dclk_w[i], ed);
            chk($sformatf("cycle_cnt_o[%0d]", i), cnt_w[i], mcnt[i]);
            chk($sformatf("done_o[%0d]", i), done_w[i], mdone[i]);
        end
    endtask

    task automatic monitors();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++)
                if (rstn_w[i][k] === 1'b1 && prev_rn[i][k] === 1'b0 && rise[i][k] < 0)
                    rise[i][k] = ecnt;
            prev_rn[i] = rstn_w[i];
        end
        if (per_on)
            for (int k = 0; k < 4; k++)
                if (dclk_w[0][k] !== prev_dc[k]) begin
                    if (last_tog[k] >= 0)
                        chk($sformatf("half_period ch%0d", k), ecnt - last_tog[k], k + 1);
                    last_tog[k] = ecnt;
                end
        prev_dc = dclk_w[0];
    endtask

    task automatic step();
        @(posedge clk);
        ecnt = rst ? 0 : ecnt + 1;
        model_edge();
        if (rst)
            for (int k = 0; k < 4; k++) begin
                rise[0][k] = -1; rise[1][k] = -1; last_tog[k] = -1;
            end
        @(negedge clk);
        compare();
        monitors();
    endtask

    task automatic check_reset_literals();
        chk("reset rst_n_o", rstn_w[0], 4'h0);
        chk("reset ce_o", ce_w[0], 4'h0);
        chk("reset div_clk_o", dclk_w[0], 4'hF);
        chk("reset cycle_cnt_o", cnt_w[0], 0);
        chk("reset done_o", done_w[0], 0);
    endtask

    task automatic check_rise_literals();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("release edge a ch%0d", k), rise[0][k], 4 + 2 * k);
            chk($sformatf("release edge b ch%0d", k), rise[1][k], 4);
        end
    endtask

    initial begin
        int          t0, c, n;
        int          pq[$];
        logic [31:0] bud;
        logic [3:0]  frz;
        rst = 1; en = 1; max_c = 0;
        div_v[0] = {8'd4, 8'd3, 8'd2, 8'd1};
        div_v[1] = 32'h0;
        prev_rn[0] = 0; prev_rn[1] = 0; prev_dc = 4'hF;
        repeat (3) step();
        check_reset_literals();

        // free run: staggered releases, periods 2/4/6/8, no done
        rst = 0; per_on = 1;
        repeat (40) step();
        per_on = 0;
        check_rise_literals();
        chk("no done unbounded", done_w[0], 0);
        chk("stagger0 D=1 ce", ce_w[1], 4'hF);

        // pause: everything holds for 5 cycles
        en = 0; c = int'(cnt_w[0]);
        repeat (5) step();
        chk("pause holds count", cnt_w[0], c);
        en = 1;
        repeat (10) step();

        // ch0 ratio 1 -> 2, then 2 -> 5 just after a pulse
        div_v[0][7:0] = 8'd2;
        step();
        n = 0;
        while (ce_w[0][0] !== 1'b1 && n < 6) begin step(); n++; end
        chk("ce0 seen before change", ce_w[0][0], 1);
        t0 = ecnt;
        div_v[0][7:0] = 8'd5;
        repeat (14) begin step(); if (ce_w[0][0] === 1'b1) pq.push_back(ecnt); end
        chk("ratio change pulse count", pq.size(), 3);
        if (pq.size() >= 3) begin
            chk("old period completes", pq[0] - t0, 2);
            chk("new period 1", pq[1] - pq[0], 5);
            chk("new period 2", pq[2] - pq[1], 5);
        end

        // budget match with en falling: no done; next enabled edge finishes
        bud = cnt_w[0] + 1; max_c = bud; en = 0;
        repeat (2) step();
        chk("en fall blocks done", done_w[0], 0);
        en = 1;
        step();
        chk("done on match", done_w[0], 1);
        chk("count at match", cnt_w[0], bud);
        chk("lowered budget done", done_w[1], 1);

        // 1-cycle reset in DONE, then budget 20
        rst = 1;
        step();
        check_reset_literals();
        rst = 0; max_c = 20;
        n = 0;
        while (done_w[0] !== 1'b1 && n < 100) begin step(); n++; end
        chk("done reached", done_w[0], 1);
        chk("budget count", cnt_w[0], 20);
        chk("budget done edge", ecnt, 30);
        check_rise_literals();
        frz = dclk_w[0];
        repeat (10) begin
            step();
            chk("ce zero in done", ce_w[0], 4'h0);
            chk("div_clk frozen", dclk_w[0], frz);
        end
        chk("count frozen", cnt_w[0], 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
